gated_click_counter: RTL and testbench
======================================

Name: gated_click_counter

Overview:
Downstream consumer of the sync/pulse/detector-gate generator. Takes the asynchronous SPAD click line, synchronizes it and classifies each click as gated (det high) or ungated. Accumulates counts over a programmable number of sync periods and hands results to the readout logic over a valid/ready handshake. Supports one-shot and continuous integration for detection-probability and QBER measurements.

Parameters:
CW, 32, width of every count accumulator and result port
SYNC_STAGES, 2, flip-flop stages on click_in before edge detection (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
click_in  input  1  raw detector click, asynchronous to clk
det_gate  input  1  detector gate from the generator's det output, synchronous to clk
sync_in  input  1  selected sync level (master or external), synchronous to clk
start  input  1  one-cycle pulse: arm a new measurement
abort  input  1  one-cycle pulse: stop the measurement, discard partial counts
continuous  input  1  1 = restart a new window automatically after each result
num_periods  input  32  sync periods per window; sampled on start; 0 is treated as 1
res_valid  output  1  result registers hold an unread result
res_ready  input  1  consumer accepts the result when res_valid & res_ready
gated_count  output  CW  clicks with det_gate high in the last window
ungated_count  output  CW  clicks with det_gate low in the last window
hit_periods  output  CW  periods containing at least one gated click
overrun  output  1  sticky: a result was overwritten before it was accepted
busy  output  1  high in ARMED or INTEGRATE

Behaviour:
- Reset (async, any state): state=IDLE; all counters, result registers, res_valid, overrun, busy=0; synchronizer flops=0; sync edge register=0.
- Click path: click_in passes through SYNC_STAGES flops, then a rising-edge detect gives click_rise. Latency is SYNC_STAGES+1 cycles from click_in rising to click_rise. A level held high counts once. det_gate is sampled unregistered in the click_rise cycle; the generator's delay_det absorbs the latency.
- Sync edge: sync_rise = sync_in & ~sync_in_q (one register).
- FSM states:
  - IDLE: on start, load num_periods (0 -> 1) into the window length register, clear the working counters, go to ARMED.
  - ARMED: wait for sync_rise, then go to INTEGRATE with period_cnt=0. Clicks in ARMED are ignored.
  - INTEGRATE: on click_rise & det_gate, increment gated_cnt and set period_hit. On click_rise & ~det_gate, increment ungated_cnt.
    - On sync_rise, add period_hit (including a hit in this cycle) to hit_cnt, clear period_hit, and increment period_cnt.
    - When period_cnt+1 equals the window length on a sync_rise, the window closes.
- Window close (same cycle):
  - Copy gated/ungated/hit counts into the result registers, including any click in the closing cycle. Set res_valid.
  - If continuous=1, clear the working counters and stay in INTEGRATE; that sync edge opens the next window with no gap. Otherwise go to IDLE.
- All working counters saturate at 2^CW-1 and never wrap.
- Handshake:
  - res_valid & res_ready clears res_valid on the next edge.
  - If a close and an accept happen in the same cycle, the new result loads, res_valid stays 1 and overrun is not set.
  - If a close happens while res_valid=1 and res_ready=0, the new result overwrites the old one and overrun is set. overrun clears only on start or rst.
  - Results stay stable while res_valid=1 unless overwritten.
- Priority: rst > abort > start > normal operation.
  - abort in any state: go to IDLE, clear the working counters, leave the result registers and res_valid untouched.
  - start in ARMED or INTEGRATE restarts: reload num_periods, clear the counters, go to ARMED.
- busy = (state==ARMED) | (state==INTEGRATE).

Test Plan:
- Basic window: num_periods=4, continuous=0, start. Send 3 clicks inside det_gate in period 1 and 1 click inside it in period 3 -> res_valid after the 5th sync_rise (the first arms), gated_count=4, ungated_count=0, hit_periods=2, state back to IDLE.
- Gate classification: 2 clicks with det low and 1 with det high in one period, num_periods=1 -> gated_count=1, ungated_count=2, hit_periods=1. A click_in held high for 50 cycles counts once.
- Boundary: a click_rise in the same cycle as the closing sync_rise -> included in the closing result. num_periods=0 behaves exactly like num_periods=1.
- Continuous and overrun: continuous=1, num_periods=2, res_ready=0 -> second result overwrites and overrun=1. With res_ready held at 1 -> no overrun and no lost sync edge between windows.
- Reset and abort mid-window: abort during INTEGRATE with 5 clicks counted -> IDLE, busy=0, prior result unchanged. rst asserted asynchronously mid-window -> all outputs 0 immediately.
- Saturation: CW=4, inject 20 gated clicks in one window -> gated_count=15.

Source files
------------

// File: rtl/gated_click_counter.sv
// Gated SPAD click counter. It integrates gated clicks, ungated clicks and hit periods
// over a programmable number of sync periods, and returns each result over a valid/ready handshake.
module gated_click_counter #(
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          click_in,
  input  logic          det_gate,
  input  logic          sync_in,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [31:0]   num_periods,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] gated_count,
  output logic [CW-1:0] ungated_count,
  output logic [CW-1:0] hit_periods,
  output logic          overrun,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  // Handshake: a result transfers on a rising clk edge where res_valid & res_ready.
  // res_valid never drops without a transfer, and a result is only replaced by a newer window.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    INTEGRATE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] click_sync;
  logic                   click_q;
  logic                   sync_in_q;
  logic                   click_rise;
  logic                   sync_rise;

  logic [31:0]   len_q;
  logic [31:0]   period_cnt;
  logic [CW-1:0] gated_cnt;
  logic [CW-1:0] ungated_cnt;
  logic [CW-1:0] hit_cnt;
  logic          period_hit;

  logic          gated_ev;
  logic          ungated_ev;
  logic          period_hit_nx;
  logic [CW-1:0] gated_nx;
  logic [CW-1:0] ungated_nx;
  logic [CW-1:0] hit_nx;
  logic          last_period;

  logic clear_work;
  logic load_len;
  logic count_en;
  logic period_end;
  logic close;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      click_sync <= '0;
      click_q    <= 1'b0;
      sync_in_q  <= 1'b0;
    end else begin
      click_sync <= {click_sync[SYNC_STAGES-2:0], click_in};
      click_q    <= click_sync[SYNC_STAGES-1];
      sync_in_q  <= sync_in;
    end
  end

  assign click_rise = click_sync[SYNC_STAGES-1] & ~click_q;
  assign sync_rise  = sync_in & ~sync_in_q;

  // Next values include any click in the current cycle, so a closing edge captures it.
  assign gated_ev      = click_rise & det_gate;
  assign ungated_ev    = click_rise & ~det_gate;
  assign period_hit_nx = period_hit | gated_ev;
  assign gated_nx      = (gated_ev && gated_cnt != CNT_MAX) ? gated_cnt + CNT_ONE : gated_cnt;
  assign ungated_nx    = (ungated_ev && ungated_cnt != CNT_MAX) ? ungated_cnt + CNT_ONE : ungated_cnt;
  assign hit_nx        = (period_hit_nx && hit_cnt != CNT_MAX) ? hit_cnt + CNT_ONE : hit_cnt;
  assign last_period   = (period_cnt == len_q - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    clear_work = 1'b0;
    load_len   = 1'b0;
    count_en   = 1'b0;
    period_end = 1'b0;
    close      = 1'b0;
    if (abort) begin
      state_nx   = IDLE;
      clear_work = 1'b1;
    end else if (start) begin
      state_nx   = ARMED;
      clear_work = 1'b1;
      load_len   = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          if (sync_rise) begin
            state_nx   = INTEGRATE;
            clear_work = 1'b1;
          end
        end
        INTEGRATE: begin
          count_en = 1'b1;
          if (sync_rise) begin
            period_end = 1'b1;
            if (last_period) begin
              close = 1'b1;
              if (!continuous) state_nx = IDLE;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= 32'd1;
      period_cnt  <= '0;
      gated_cnt   <= '0;
      ungated_cnt <= '0;
      hit_cnt     <= '0;
      period_hit  <= 1'b0;
    end else begin
      if (load_len) len_q <= (num_periods == 32'd0) ? 32'd1 : num_periods;
      // On a close the sync edge that ends this window also opens the next one.
      if (clear_work || close) begin
        period_cnt  <= '0;
        gated_cnt   <= '0;
        ungated_cnt <= '0;
        hit_cnt     <= '0;
        period_hit  <= 1'b0;
      end else if (count_en) begin
        gated_cnt   <= gated_nx;
        ungated_cnt <= ungated_nx;
        if (period_end) begin
          hit_cnt    <= hit_nx;
          period_hit <= 1'b0;
          period_cnt <= period_cnt + 32'd1;
        end else begin
          period_hit <= period_hit_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid     <= 1'b0;
      overrun       <= 1'b0;
      gated_count   <= '0;
      ungated_count <= '0;
      hit_periods   <= '0;
    end else begin
      if (close) begin
        gated_count   <= gated_nx;
        ungated_count <= ungated_nx;
        hit_periods   <= hit_nx;
        res_valid     <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (start && !abort) overrun <= 1'b0;
    end
  end

  assign busy      = (state == ARMED) || (state == INTEGRATE);
  assign fsm_state = state;

endmodule

// File: tb/tb_gated_click_counter.sv
// Bench for gated_click_counter: directed scenarios plus randomized windows, all
// checked against a period-list model of the counting rules.
module tb_gated_click_counter;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        click_in = 1'b0;
  logic        det_gate = 1'b0;
  logic        sync_in = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] num_periods = 32'd0;
  logic        res_ready = 1'b0;

  logic        res_valid, overrun, busy;
  logic [1:0]  fsm_state;
  logic [31:0] gated_count, ungated_count, hit_periods;

  logic        s_res_valid, s_overrun, s_busy;
  logic [1:0]  s_fsm_state;
  logic [3:0]  s_gated_count, s_ungated_count, s_hit_periods;

  int errors = 0;
  int checks = 0;

  gated_click_counter #(.CW(32), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .click_in(click_in), .det_gate(det_gate), .sync_in(sync_in),
    .start(start), .abort(abort), .continuous(continuous), .num_periods(num_periods),
    .res_valid(res_valid), .res_ready(res_ready), .gated_count(gated_count),
    .ungated_count(ungated_count), .hit_periods(hit_periods), .overrun(overrun),
    .busy(busy), .fsm_state(fsm_state)
  );

  gated_click_counter #(.CW(4), .SYNC_STAGES(SS)) dut_s (
    .clk(clk), .rst(rst), .click_in(click_in), .det_gate(det_gate), .sync_in(sync_in),
    .start(start), .abort(abort), .continuous(continuous), .num_periods(num_periods),
    .res_valid(s_res_valid), .res_ready(res_ready), .gated_count(s_gated_count),
    .ungated_count(s_ungated_count), .hit_periods(s_hit_periods), .overrun(s_overrun),
    .busy(s_busy), .fsm_state(s_fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: a window is a list of per-period gated click counts plus an ungated total.
  int          m_phase = 0;
  int          m_len = 1;
  int          pg[$];
  int          m_ung = 0;
  bit          exp_valid = 1'b0;
  bit          exp_overrun = 1'b0;
  logic [95:0] exp_q[$];
  logic [95:0] e;
  logic [95:0] last_res;

  function automatic void m_start(input logic [31:0] n);
    m_phase = 1;
    m_len = (n == 32'd0) ? 1 : int'(n);
    pg.delete();
    m_ung = 0;
    exp_overrun = 1'b0;
  endfunction

  function automatic void m_abort();
    m_phase = 0;
    pg.delete();
    m_ung = 0;
  endfunction

  function automatic void m_click(input bit det);
    if (m_phase == 2) begin
      if (det) pg[pg.size()-1] = pg[pg.size()-1] + 1;
      else     m_ung = m_ung + 1;
    end
  endfunction

  function automatic void m_sync();
    int g, h;
    if (m_phase == 1) begin
      m_phase = 2;
      pg.delete();
      pg.push_back(0);
      m_ung = 0;
    end else if (m_phase == 2) begin
      if (pg.size() == m_len) begin
        g = 0;
        h = 0;
        foreach (pg[i]) begin
          g = g + pg[i];
          if (pg[i] > 0) h = h + 1;
        end
        exp_q.push_back({32'(g), 32'(m_ung), 32'(h)});
        if (exp_valid && !res_ready) exp_overrun = 1'b1;
        exp_valid = 1'b1;
        pg.delete();
        m_ung = 0;
        if (continuous) pg.push_back(0);
        else            m_phase = 0;
      end else begin
        pg.push_back(0);
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [31:0] n);
    num_periods = n;
    start = 1'b1;
    m_start(n);
    step(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    m_abort();
    step(1);
    abort = 1'b0;
  endtask

  task automatic do_sync();
    m_sync();
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    step(1);
  endtask

  task automatic do_click(input bit det);
    m_click(det);
    det_gate = det;
    click_in = 1'b1;
    step(2);
    click_in = 1'b0;
    step(SS + 1);
  endtask

  task automatic do_accept();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic rand_period();
    int k;
    k = $urandom_range(0, 3);
    for (int j = 0; j < k; j++) do_click(1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
    checks++; if (gated_count !== 32'd0) begin errors++; $display("FAIL reset_gated: got %0d want 0", gated_count); end
    checks++; if (ungated_count !== 32'd0) begin errors++; $display("FAIL reset_ungated: got %0d want 0", ungated_count); end
    checks++; if (hit_periods !== 32'd0) begin errors++; $display("FAIL reset_hit: got %0d want 0", hit_periods); end
    checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: overrun=%0b busy=%0b want 0 0", overrun, busy); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic_window();
    res_ready = 1'b0;
    continuous = 1'b0;
    do_start(32'd4);
    checks++; if (busy !== 1'b1 || fsm_state !== 2'd1) begin errors++; $display("FAIL basic_armed: busy=%0b state=%0d want 1 1", busy, fsm_state); end
    do_sync();
    for (int i = 0; i < 3; i++) do_click(1'b1);
    do_sync();
    do_sync();
    do_click(1'b1);
    do_sync();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", res_valid); end
    do_sync();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", res_valid); end
    checks++; if (gated_count !== 32'd4) begin errors++; $display("FAIL basic_gated: got %0d want 4", gated_count); end
    checks++; if (ungated_count !== 32'd0) begin errors++; $display("FAIL basic_ungated: got %0d want 0", ungated_count); end
    checks++; if (hit_periods !== 32'd2) begin errors++; $display("FAIL basic_hit: got %0d want 2", hit_periods); end
    checks++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL basic_idle: busy=%0b state=%0d want 0 0", busy, fsm_state); end
    exp_q.delete();
    do_accept();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %0b want 0", res_valid); end
  endtask

  task automatic test_gate_class();
    do_start(32'd1);
    do_sync();
    do_click(1'b0);
    do_click(1'b0);
    do_click(1'b1);
    do_sync();
    checks++; if (gated_count !== 32'd1) begin errors++; $display("FAIL class_gated: got %0d want 1", gated_count); end
    checks++; if (ungated_count !== 32'd2) begin errors++; $display("FAIL class_ungated: got %0d want 2", ungated_count); end
    checks++; if (hit_periods !== 32'd1) begin errors++; $display("FAIL class_hit: got %0d want 1", hit_periods); end
    do_accept();
    do_start(32'd1);
    do_sync();
    m_click(1'b1);
    det_gate = 1'b1;
    click_in = 1'b1;
    step(50);
    click_in = 1'b0;
    step(SS + 1);
    do_sync();
    checks++; if (gated_count !== 32'd1 || ungated_count !== 32'd0) begin errors++; $display("FAIL held_click: got %0d/%0d want 1/0", gated_count, ungated_count); end
    exp_q.delete();
    do_accept();
  endtask

  task automatic test_boundary();
    do_start(32'd0);
    do_sync();
    do_click(1'b1);
    m_click(1'b1);
    m_sync();
    det_gate = 1'b1;
    click_in = 1'b1;
    step(SS);
    sync_in = 1'b1;
    step(1);
    sync_in = 1'b0;
    click_in = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL zero_len_close: valid=%0b want 1", res_valid); end
    checks++; if (gated_count !== 32'd2 || hit_periods !== 32'd1) begin errors++; $display("FAIL boundary_click: gated=%0d hit=%0d want 2 1", gated_count, hit_periods); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_idle: busy=%0b want 0", busy); end
    step(SS + 1);
    exp_q.delete();
    do_accept();
  endtask

  task automatic test_random_windows();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 4);
      do_start(32'(n));
      do_sync();
      for (int p = 0; p < n; p++) begin
        rand_period();
        do_sync();
      end
      checks++;
      if (exp_q.size() != 1) begin
        errors++; $display("FAIL rand_queue: depth %0d want 1", exp_q.size());
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (res_valid !== 1'b1 || {gated_count, ungated_count, hit_periods} !== e) begin
          errors++;
          $display("FAIL rand_window: valid=%0b got %0d/%0d/%0d want %0d/%0d/%0d", res_valid,
                   gated_count, ungated_count, hit_periods, e[95:64], e[63:32], e[31:0]);
        end
      end
      do_accept();
    end
  endtask

  task automatic test_continuous_overrun();
    res_ready = 1'b0;
    continuous = 1'b1;
    do_start(32'd2);
    do_sync();
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < 2; p++) begin
        rand_period();
        do_sync();
      end
      e = exp_q.pop_front();
      checks++; if ({gated_count, ungated_count, hit_periods} !== e) begin errors++; $display("FAIL cont_result%0d: got %0d/%0d/%0d want %0d/%0d/%0d", w, gated_count, ungated_count, hit_periods, e[95:64], e[63:32], e[31:0]); end
      checks++; if (overrun !== exp_overrun || res_valid !== 1'b1) begin errors++; $display("FAIL cont_overrun%0d: overrun=%0b valid=%0b want %0b 1", w, overrun, res_valid, exp_overrun); end
    end
    do_abort();
    checks++; if (busy !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL abort_keeps_overrun: busy=%0b overrun=%0b want 0 1", busy, overrun); end
    do_accept();
    res_ready = 1'b1;
    do_start(32'd2);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL start_clears_overrun: got %0b want 0", overrun); end
    do_sync();
    for (int w = 0; w < 3; w++) begin
      rand_period();
      do_sync();
      rand_period();
      m_sync();
      sync_in = 1'b1;
      step(1);
      sync_in = 1'b0;
      e = exp_q.pop_front();
      last_res = e;
      checks++; if (res_valid !== 1'b1 || {gated_count, ungated_count, hit_periods} !== e) begin errors++; $display("FAIL gapless%0d: valid=%0b got %0d/%0d/%0d want %0d/%0d/%0d", w, res_valid, gated_count, ungated_count, hit_periods, e[95:64], e[63:32], e[31:0]); end
      step(1);
      exp_valid = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL gapless_accept%0d: valid=%0b want 0", w, res_valid); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL gapless_overrun: got %0b want 0", overrun); end
    do_abort();
    res_ready = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic test_abort();
    do_start(32'd10);
    do_sync();
    for (int i = 0; i < 5; i++) do_click(1'b1);
    checks++; if (busy !== 1'b1 || fsm_state !== 2'd2) begin errors++; $display("FAIL abort_pre: busy=%0b state=%0d want 1 2", busy, fsm_state); end
    do_abort();
    checks++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL abort_idle: busy=%0b state=%0d want 0 0", busy, fsm_state); end
    checks++; if (res_valid !== 1'b0 || {gated_count, ungated_count, hit_periods} !== last_res) begin errors++; $display("FAIL abort_result: valid=%0b got %0d/%0d/%0d want %0d/%0d/%0d", res_valid, gated_count, ungated_count, hit_periods, last_res[95:64], last_res[63:32], last_res[31:0]); end
    do_start(32'd1);
    do_sync();
    do_click(1'b0);
    do_sync();
    e = exp_q.pop_front();
    checks++; if ({gated_count, ungated_count, hit_periods} !== e) begin errors++; $display("FAIL after_abort: got %0d/%0d/%0d want %0d/%0d/%0d", gated_count, ungated_count, hit_periods, e[95:64], e[63:32], e[31:0]); end
    do_accept();
  endtask

  task automatic test_saturation();
    do_start(32'd1);
    do_sync();
    for (int i = 0; i < 20; i++) do_click(1'b1);
    do_sync();
    e = exp_q.pop_front();
    checks++; if (gated_count !== e[95:64]) begin errors++; $display("FAIL sat_wide: got %0d want %0d", gated_count, e[95:64]); end
    checks++; if (s_gated_count !== ((e[95:64] > 32'd15) ? 4'd15 : e[67:64])) begin errors++; $display("FAIL sat_narrow: got %0d want 15", s_gated_count); end
    checks++; if (s_hit_periods !== 4'd1 || s_res_valid !== 1'b1) begin errors++; $display("FAIL sat_hit: hit=%0d valid=%0b want 1 1", s_hit_periods, s_res_valid); end
  endtask

  task automatic test_async_reset();
    do_start(32'd3);
    do_sync();
    do_click(1'b1);
    do_click(1'b0);
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL prereset: valid=%0b busy=%0b want 1 1", res_valid, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL async_flags: valid=%0b overrun=%0b busy=%0b state=%0d want 0", res_valid, overrun, busy, fsm_state); end
    checks++; if (gated_count !== 32'd0 || ungated_count !== 32'd0 || hit_periods !== 32'd0) begin errors++; $display("FAIL async_counts: got %0d/%0d/%0d want 0", gated_count, ungated_count, hit_periods); end
    checks++; if (s_gated_count !== 4'd0 || s_busy !== 1'b0) begin errors++; $display("FAIL async_narrow: gated=%0d busy=%0b want 0 0", s_gated_count, s_busy); end
    @(negedge clk);
    rst = 1'b0;
    m_abort();
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    exp_q.delete();
    step(2);
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_gate_class();
    test_boundary();
    test_random_windows();
    test_continuous_overrun();
    test_abort();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
